// File: rtl/set_speed_pkg.sv
// set_speed_pkg: shared state encodings, rate-select codes and helpers for set_speed_ctrl.
//   States IDLE/HOLD/RAMP, rate codes SEL_1HZ..SEL_100HZ, tick counter width and
//   saturating rate-step functions.
package set_speed_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] RAMP = 2'd2;

    localparam logic [1:0] SEL_1HZ   = 2'd0;
    localparam logic [1:0] SEL_20HZ  = 2'd1;
    localparam logic [1:0] SEL_50HZ  = 2'd2;
    localparam logic [1:0] SEL_100HZ = 2'd3;

    function automatic int tick_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    // Next faster rate, saturating at 100 Hz.
    function automatic logic [1:0] next_sel(input logic [1:0] s);
        return (s == SEL_1HZ)  ? SEL_20HZ :
               (s == SEL_20HZ) ? SEL_50HZ : SEL_100HZ;
    endfunction

endpackage

// File: rtl/btn_rise_detect.sv
// btn_rise_detect: optional two-flop synchronizer plus rising-edge detector for the set button.
//   Ports: clk, rst_n (async active-low), btn (raw level) -> level (level seen by the FSM),
//          rise (single-cycle press strobe).
//   Macro SET_SPEED_SYNC_EN: when defined, btn is double-flopped before edge detection.
module btn_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic btn_d;
    logic armed;

`ifdef SET_SPEED_SYNC_EN
    logic [1:0] sync;
    logic [2:0] arm;
    // Edge detection stays disabled until the synchronizer and btn_d hold real samples,
    // so a button held through reset is not mistaken for a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            arm  <= '0;
        end else begin
            sync <= {sync[0], btn};
            arm  <= {arm[1:0], 1'b1};
        end
    end
    assign level = sync[1];
    assign armed = arm[2];
`else
    logic arm;
    // First cycle out of reset only loads btn_d; detection is enabled afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            arm <= 1'b0;
        else
            arm <= 1'b1;
    end
    assign level = btn;
    assign armed = arm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            btn_d <= 1'b0;
        else
            btn_d <= level;
    end

    assign rise = armed & level & ~btn_d;

endmodule

// File: rtl/set_speed_ctrl.sv
// set_speed_ctrl: press-and-hold auto-repeat controller sequencing the frequency_generator rate select.
//   Ports: clk, rst_n (async active-low), btn_inc (set button), ena_5hz (5 Hz timebase tick),
//          ena (tick at selected rate) -> sel (rate select), inc_pulse (increment strobe),
//          busy (not idle), max_speed (ramping at 100 Hz).
//   Macro SET_SPEED_SYNC_EN: synchronize btn_inc inside btn_rise_detect.
module set_speed_ctrl
    import set_speed_pkg::*;
#(
    parameter int HOLD_TICKS = 5,
    parameter int STEP_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc,
    input  logic       ena_5hz,
    input  logic       ena,
    output logic [1:0] sel,
    output logic       inc_pulse,
    output logic       busy,
    output logic       max_speed
);

    localparam int TW = tick_width(HOLD_TICKS, STEP_TICKS);

    logic [1:0]    state, state_n, sel_n;
    logic [TW-1:0] tick_cnt, cnt_n;
    logic          inc_n, level, rise;

    btn_rise_detect u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_inc),
        .level (level),
        .rise  (rise)
    );

    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = tick_cnt;
        inc_n   = 1'b0;
        case (state)
            IDLE: begin
                sel_n = SEL_1HZ;
                cnt_n = '0;
                if (rise) begin
                    inc_n   = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                // Release wins over a coincident hold-expiry tick.
                if (!level) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (ena_5hz) begin
                    if (tick_cnt == TW'(HOLD_TICKS - 1)) begin
                        state_n = RAMP;
                        sel_n   = SEL_1HZ;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = tick_cnt + TW'(1);
                    end
                end
            end
            RAMP: begin
                if (!level) begin
                    state_n = IDLE;
                    sel_n   = SEL_1HZ;
                    cnt_n   = '0;
                end else begin
                    inc_n = ena;
                    if (ena_5hz) begin
                        if (sel == SEL_100HZ) begin
                            cnt_n = '0;
                        end else if (tick_cnt == TW'(STEP_TICKS - 1)) begin
                            sel_n = next_sel(sel);
                            cnt_n = '0;
                        end else begin
                            cnt_n = tick_cnt + TW'(1);
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                sel_n   = SEL_1HZ;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= SEL_1HZ;
            tick_cnt  <= '0;
            inc_pulse <= 1'b0;
            busy      <= 1'b0;
            max_speed <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            tick_cnt  <= cnt_n;
            inc_pulse <= inc_n;
            busy      <= state_n != IDLE;
            max_speed <= (state_n == RAMP) && (sel_n == SEL_100HZ);
        end
    end

endmodule
